// File: rtl/gyro_var_snapshot_ctrl_if.sv
// Bus between the snapshot sequencer (master side) and the IMU read mux /
// shadow register file it walks (slave side).
interface gyro_var_snapshot_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 6
);
  logic              i_trigger;
  logic [DATA_W-1:0] i_var_data;
  logic [IDX_W-1:0]  o_var_sel;
  logic              o_wr_en;
  logic [IDX_W-1:0]  o_wr_addr;
  logic [DATA_W-1:0] o_wr_data;
  logic              o_busy;
  logic              o_done;
  logic [15:0]       o_seq_cnt;
  logic              o_overrun;
  logic [7:0]        o_overrun_cnt;

  modport master (
    input  i_trigger, i_var_data,
    output o_var_sel, o_wr_en, o_wr_addr, o_wr_data, o_busy, o_done,
           o_seq_cnt, o_overrun, o_overrun_cnt
  );

  modport slave (
    output i_trigger, i_var_data,
    input  o_var_sel, o_wr_en, o_wr_addr, o_wr_data, o_busy, o_done,
           o_seq_cnt, o_overrun, o_overrun_cnt
  );
endinterface

// File: rtl/gyro_var_snapshot_ctrl.sv
// Walks the IMU variable mux and copies one coherent set into the shadow file.
// Optional periodic self-trigger is enabled by defining GYRO_SNAP_AUTO_TRIG_EN.
module gyro_var_snapshot_ctrl #(
  parameter int NUM_VARS = 60,
  parameter int DATA_W   = 32,
  parameter int IDX_W    = 6,
  parameter int MUX_LAT  = 1
) (
  input  logic clk,
  input  logic rst,
`ifdef GYRO_SNAP_AUTO_TRIG_EN
  input  logic [23:0] i_period,
`endif
  gyro_var_snapshot_ctrl_if.master bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  localparam int                PIPE_D     = MUX_LAT + 1;
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(NUM_VARS - 1);
  localparam logic [2:0]        DRAIN_LAST = 3'(MUX_LAT);

  state_t                          state_q, state_d;
  logic [IDX_W-1:0]                sel_q, sel_d;
  logic [2:0]                      drain_cnt_q, drain_cnt_d;
  logic [PIPE_D-1:0]               pipe_vld_q, pipe_vld_d;
  logic [PIPE_D-1:0][IDX_W-1:0]    pipe_idx_q, pipe_idx_d;
  logic [DATA_W-1:0]               wr_data_q, wr_data_d;
  logic                            busy_q, busy_d;
  logic                            done_q, done_d;
  logic [15:0]                     seq_cnt_q, seq_cnt_d;
  logic                            overrun_q, overrun_d;
  logic [7:0]                      overrun_cnt_q, overrun_cnt_d;
  logic                            trig;

`ifdef GYRO_SNAP_AUTO_TRIG_EN
  logic [23:0] period_cnt_q, period_cnt_d;
  logic        auto_trig;

  // A zero count means "not loaded yet" (reset release or period re-enabled).
  always_comb begin
    period_cnt_d = period_cnt_q;
    auto_trig    = 1'b0;
    if (i_period == 24'd0) begin
      period_cnt_d = 24'd0;
    end else if (period_cnt_q == 24'd0) begin
      period_cnt_d = i_period;
    end else if (period_cnt_q == 24'd1) begin
      auto_trig    = 1'b1;
      period_cnt_d = i_period;
    end else begin
      period_cnt_d = period_cnt_q - 24'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) period_cnt_q <= 24'd0;
    else     period_cnt_q <= period_cnt_d;
  end

  assign trig = bus.i_trigger | auto_trig;
`else
  assign trig = bus.i_trigger;
`endif

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    drain_cnt_d = drain_cnt_q;
    case (state_q)
      IDLE: begin
        sel_d = '0;
        if (trig) state_d = ISSUE;
      end
      ISSUE: begin
        if (sel_q == LAST_IDX) begin
          state_d     = DRAIN;
          drain_cnt_d = 3'd0;
        end else begin
          sel_d = sel_q + IDX_W'(1);
        end
      end
      DRAIN: begin
        if (drain_cnt_q == DRAIN_LAST) state_d = DONE;
        else                           drain_cnt_d = drain_cnt_q + 3'd1;
      end
      DONE: begin
        state_d = IDLE;
        sel_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Each presented index rides the valid/index pipe until its mux data is due.
  always_comb begin
    pipe_vld_d    = '0;
    pipe_idx_d    = '0;
    pipe_vld_d[0] = (state_q == ISSUE);
    pipe_idx_d[0] = sel_q;
    for (int i = 1; i < PIPE_D; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_idx_d[i] = pipe_idx_q[i-1];
    end
    wr_data_d = pipe_vld_d[PIPE_D-1] ? bus.i_var_data : wr_data_q;

    busy_d        = (state_d != IDLE);
    done_d        = (state_d == DONE);
    seq_cnt_d     = done_d ? seq_cnt_q + 16'd1 : seq_cnt_q;
    overrun_d     = trig && (state_q != IDLE);
    overrun_cnt_d = (overrun_d && overrun_cnt_q != 8'hFF) ? overrun_cnt_q + 8'd1
                                                          : overrun_cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      sel_q         <= '0;
      drain_cnt_q   <= 3'd0;
      pipe_vld_q    <= '0;
      pipe_idx_q    <= '0;
      wr_data_q     <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      seq_cnt_q     <= 16'd0;
      overrun_q     <= 1'b0;
      overrun_cnt_q <= 8'd0;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      drain_cnt_q   <= drain_cnt_d;
      pipe_vld_q    <= pipe_vld_d;
      pipe_idx_q    <= pipe_idx_d;
      wr_data_q     <= wr_data_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      seq_cnt_q     <= seq_cnt_d;
      overrun_q     <= overrun_d;
      overrun_cnt_q <= overrun_cnt_d;
    end
  end

  assign bus.o_var_sel     = sel_q;
  assign bus.o_wr_en       = pipe_vld_q[PIPE_D-1];
  assign bus.o_wr_addr     = pipe_idx_q[PIPE_D-1];
  assign bus.o_wr_data     = wr_data_q;
  assign bus.o_busy        = busy_q;
  assign bus.o_done        = done_q;
  assign bus.o_seq_cnt     = seq_cnt_q;
  assign bus.o_overrun     = overrun_q;
  assign bus.o_overrun_cnt = overrun_cnt_q;

endmodule

// File: doc/gyro_var_snapshot_ctrl.md
Name: gyro_var_snapshot_ctrl

Overview:
Sequencer that captures a coherent snapshot of the gyro/IMU input variable bank into a shadow register file. The CPU then reads one consistent set instead of a live, tearing set. On each trigger, the block walks a select index across NUM_VARS inputs through an external read mux and writes each sampled word into the shadow file. It also tracks sequence count and overruns. It sits between the IMU datapath variables and the Avalon-visible variable register block; the latch-trigger pulse from that block is a typical i_trigger source.

Parameters:
NUM_VARS, 60, number of input variables captured per snapshot (1..64)
DATA_W, 32, variable width in bits
IDX_W, 6, width of select/address index; 2^IDX_W >= NUM_VARS
MUX_LAT, 1, cycles from o_var_sel change to valid i_var_data (0..4)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
i_trigger  in  1  single-cycle snapshot request
i_var_data  in  DATA_W  muxed variable selected by o_var_sel, valid MUX_LAT cycles after sel
o_var_sel  out  IDX_W  read-mux select index
o_wr_en  out  1  shadow file write strobe
o_wr_addr  out  IDX_W  shadow file write address
o_wr_data  out  DATA_W  shadow file write data
o_busy  out  1  snapshot in progress
o_done  out  1  one-cycle pulse, snapshot complete
o_seq_cnt  out  16  completed-snapshot counter
o_overrun  out  1  one-cycle pulse, trigger dropped
o_overrun_cnt  out  8  dropped-trigger counter

Behaviour:
- Reset (rst=1, async): state IDLE. All outputs are 0: o_var_sel, o_wr_en, o_wr_addr, o_wr_data, o_busy, o_done, o_seq_cnt, o_overrun, o_overrun_cnt. The valid pipeline is cleared.
- Reset mid-snapshot: the snapshot is abandoned. No further writes occur and o_done does not pulse. Shadow contents are left partially updated; the CPU reads o_seq_cnt to detect this.
- All outputs are registered.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE, i_trigger=1 at edge E0 -> ISSUE, with o_var_sel=0 and o_busy=1 from cycle 1.
- ISSUE: o_var_sel increments once per cycle. After the cycle presenting NUM_VARS-1 -> DRAIN. o_var_sel holds NUM_VARS-1 through DRAIN, then returns to 0 in IDLE.
- Write pipeline: each select value presented in cycle c enters a (MUX_LAT+1)-deep valid/index shift register. In cycle c+MUX_LAT+1, o_wr_en=1, o_wr_addr=that index, and o_wr_data=i_var_data registered at the end of cycle c+MUX_LAT.
- Addresses are written in ascending order 0..NUM_VARS-1, exactly once each, on contiguous cycles.
- DRAIN lasts MUX_LAT+1 cycles, until the last write has issued -> DONE.
- DONE (1 cycle): o_done=1, o_seq_cnt increments (0xFFFF wraps to 0x0000), o_busy=1 -> IDLE.
- Latency: trigger edge to o_done is NUM_VARS+MUX_LAT+2 cycles. o_busy is high for exactly that many cycles.
- Trigger while busy (ISSUE/DRAIN/DONE): the trigger is dropped and not queued. o_overrun pulses the next cycle. o_overrun_cnt increments and saturates at 0xFF. The snapshot in progress is unaffected.
- Trigger in the first IDLE cycle after DONE is accepted normally, so back-to-back snapshots are possible with a gap of 1 cycle.
- i_trigger held high is treated as one trigger per accept opportunity. Cycles spent busy each count as overrun.
- o_wr_en is never asserted outside a snapshot.

Optional Feature:
Macro GYRO_SNAP_AUTO_TRIG_EN.
- Defined: adds input i_period (24 bits) and an internal down-counter.
  - The counter reloads with i_period on reset release or on reaching 0, and issues an internal trigger pulse on reaching 0.
  - The effective trigger is i_trigger OR the internal trigger. Overrun rules apply to both.
  - i_period=0 disables auto-trigger; the counter is held at 0 with no pulse.
- Undefined: no i_period port and no counter; snapshots are triggered only by i_trigger.

Test Plan:
1. NUM_VARS=4, MUX_LAT=1; i_var_data = 0x100+sel; pulse i_trigger at E0 -> o_var_sel 0,1,2,3 in cycles 1-4; o_wr_en in cycles 3-6 with (addr,data) = (0,0x100),(1,0x101),(2,0x102),(3,0x103); o_done in cycle 7; o_seq_cnt=1; o_busy cycles 1-7 only.
2. Same config; second trigger in cycle 3 -> o_overrun in cycle 4; o_overrun_cnt=1; exactly 4 writes; o_seq_cnt=1. Trigger in cycle 8 -> accepted, o_seq_cnt=2 in cycle 15.
3. Force o_seq_cnt path through 65536 snapshots (or preload via a short-run bench) -> value after 0xFFFF is 0x0000. Hold i_trigger high for 300 busy cycles -> o_overrun_cnt saturates at 0xFF.
4. Assert rst in cycle 3 of a snapshot -> all outputs 0 immediately; no o_wr_en or o_done afterward. A new trigger after release -> full 4-write snapshot; o_seq_cnt=1.
5. MUX_LAT=0 and MUX_LAT=4, NUM_VARS=60 -> 60 ascending writes with data matching sel; o_done at E0+62 and E0+66 respectively.
6. GYRO_SNAP_AUTO_TRIG_EN defined, i_period=100, NUM_VARS=4 -> snapshot every 100 cycles with no overrun. i_period=5 -> overrun pulses, one snapshot per busy window. i_period=0 -> no snapshots.
